prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Receive-side PRBS checker for the serial bit stream produced by the team's 26-bit LFSR generator.
//  - Self-synchronises to the incoming bit stream.
//  - Declares lock, then counts bit errors against its own locally predicted sequence.
//  - Sits at the far end of a link or loopback, opposite the LFSR generator.
// PARAMETERS
//  WIDTH      26            LFSR length; must match the generator
//  TAPS       26'h2000023   tap mask; bit k-1 set => b[n-k] feeds b[n] (x^26+x^6+x^2+x+1)
//  LOCK_CNT   32            consecutive matches after fill required to declare lock
//  WIN_LEN    1024          valid bits per error-monitor window while locked
//  ERR_LIMIT  16            errors within one window that force loss of lock
//  CNT_W      16            width of err_cnt
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  din_vld    in   1      din carries a valid stream bit this cycle
//  din        in   1      received serial bit
//  cnt_clr    in   1      synchronous clear of err_cnt
//  locked     out  1      checker is in LOCKED
//  err_pulse  out  1      one-cycle pulse on a mismatched bit while LOCKED
//  err_cnt    out  CNT_W  saturating count of errors seen while LOCKED
// BEHAVIOUR
//  Reset values
//  - All outputs 0; state SEARCH; shift register, fill counter, match counter and window counters all 0.
//  Predictor
//  - pred = XOR of sreg bits selected by TAPS, where sreg[k-1] = b[n-k].
//  - Only din_vld cycles advance anything; when din_vld=0 every register holds.
//  SEARCH
//  - Shift din into sreg and count fills.
//  - After WIDTH valid bits: go to VERIFY, unless sreg == 0, in which case stay in SEARCH and the fill count saturates.
//  VERIFY
//  - Shift din into sreg.
//  - Match: match count +1.
//  - Mismatch: match count = 0 and restart fill; return to SEARCH.
//  - LOCK_CNT consecutive matches: go to LOCKED.
//  LOCKED
//  - Shift pred, not din, into sreg, so a single channel error is counted once and never multiplied.
//  - Mismatch: err_pulse = 1 on the next cycle; err_cnt +1, saturating at all-ones; window error count +1.
//  - At the end of each WIN_LEN-bit window, the window bit and error counts are reset to 0.
//  - Window error count reaching ERR_LIMIT: go to SEARCH and clear sreg, fill count and window counts; err_cnt is kept.
//  Timing
//  - All outputs are registered, with 1-cycle latency from the din_vld sample.
//  - locked rises on the cycle after the LOCK_CNT-th match and falls on the cycle after the ERR_LIMIT-th error.
//  Boundaries
//  - Minimum time to lock from reset: WIDTH+LOCK_CNT valid bits.
//  - cnt_clr in the same cycle as an error: clear wins, so err_cnt = 0; err_pulse still fires.
//  - ERR_LIMIT-th error coincident with window end: loss of lock wins.
//  - Reset mid-operation: immediate return to reset values.
// CONFIGURATION
//  PRBS_CHK_ERRCNT_EN
//  - Defined: err_cnt counter and cnt_clr are implemented as above.
//  - Undefined: err_cnt is tied to 0 and cnt_clr is ignored; err_pulse, locked and loss-of-lock are unchanged.
//  - The port list is identical in both builds.
// STRUCTURE
//  Shared include prbs_defs.vh
//  - State encodings: SEARCH=2'd0, VERIFY=2'd1, LOCKED=2'd2.
//  - Default TAPS constant.
//  - Default WIDTH, shared with the generator.
//  Sub-module prbs_predict (combinational)
//  - Computes the tap XOR (sreg, TAPS -> pred).
//  - Also reused by the generator.
// TESTING
//  1. rst_n=0 mid-lock -> locked=0, err_pulse=0, err_cnt=0 immediately; relock after 58 clean bits.
//  2. Clean stream from the generator seeded 26'b1_1010 -> locked=1 after 58 valid bits; err_cnt=0 over 4000 bits.
//  3. Single bit inverted 500 bits after lock -> exactly one err_pulse; err_cnt=1; locked remains 1.
//  4. Constant-zero input for 500 bits -> locked never asserts; state stays SEARCH.
//  5. 16 errors inside one 1024-bit window -> locked drops the next cycle; err_cnt=16; relock after 58 clean bits.
//  6. din_vld random 50% duty, with cnt_clr pulsed alongside an error -> lock at the 58th valid bit; err_cnt=0 after the clear.

Source files
------------

// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS generator/checker pair: state encodings and
// the default LFSR length and tap mask, so both ends of the link agree.
package prbs_checker_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int                    PRBS_WIDTH = 26;
  // x^26 + x^6 + x^2 + x + 1; bit k-1 set means b[n-k] feeds b[n]
  localparam logic [PRBS_WIDTH-1:0] PRBS_TAPS  = 26'h2000023;

endpackage

// File: rtl/prbs_predict.sv
// Combinational LFSR next-bit predictor: XOR of the history bits selected by
// TAPS, where sreg[k-1] holds b[n-k]. Shared with the generator.
module prbs_predict
  import prbs_checker_pkg::*;
#(
  parameter int               WIDTH = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = PRBS_TAPS
) (
  input  logic [WIDTH-1:0] sreg,
  output logic             pred
);

  assign pred = ^(sreg & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises, locks, then counts bit errors.
// Build option PRBS_CHK_ERRCNT_EN enables the err_cnt counter and cnt_clr.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int               WIDTH     = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] TAPS      = PRBS_TAPS,
  parameter int               LOCK_CNT  = 32,
  parameter int               WIN_LEN   = 1024,
  parameter int               ERR_LIMIT = 16,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_vld,
  input  logic             din,
  input  logic             cnt_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WBIT_W  = $clog2(WIN_LEN);
  localparam int WERR_W  = $clog2(ERR_LIMIT + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WBIT_W-1:0]  WBIT_LAST  = WBIT_W'(WIN_LEN - 1);
  localparam logic [WERR_W-1:0]  WERR_LIM   = WERR_W'(ERR_LIMIT);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    sreg_q, sreg_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [WBIT_W-1:0]   wbit_q, wbit_d;
  logic [WERR_W-1:0]   werr_q, werr_d;
  logic                pulse_q, pulse_d;
  logic                locked_q, locked_d;

  logic                pred;
  logic                err_hit;
  logic [WIDTH-1:0]    sreg_din, sreg_pred;
  logic [FILL_W-1:0]   fill_nxt;
  logic [WERR_W-1:0]   werr_nxt;

  prbs_predict #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_predict (
    .sreg (sreg_q),
    .pred (pred)
  );

  assign sreg_din  = {sreg_q[WIDTH-2:0], din};
  assign sreg_pred = {sreg_q[WIDTH-2:0], pred};
  assign fill_nxt  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign werr_nxt  = werr_q + WERR_W'(din ^ pred);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    fill_d  = fill_q;
    match_d = match_q;
    wbit_d  = wbit_q;
    werr_d  = werr_q;
    pulse_d = 1'b0;
    err_hit = 1'b0;
    if (din_vld) begin
      unique case (state_q)
        ST_SEARCH: begin
          sreg_d = sreg_din;
          fill_d = fill_nxt;
          // an all-zero history is the LFSR lock-up state; keep filling
          if (fill_nxt == FILL_FULL && sreg_din != '0) begin
            state_d = ST_VERIFY;
            match_d = '0;
          end
        end
        ST_VERIFY: begin
          sreg_d = sreg_din;
          if (din == pred) begin
            if (match_q == MATCH_LAST) begin
              state_d = ST_LOCKED;
              match_d = '0;
              wbit_d  = '0;
              werr_d  = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            state_d = ST_SEARCH;
            match_d = '0;
            fill_d  = '0;
          end
        end
        ST_LOCKED: begin
          // free-running on our own prediction so one channel error counts once
          sreg_d  = sreg_pred;
          pulse_d = din ^ pred;
          err_hit = din ^ pred;
          if (werr_nxt == WERR_LIM) begin
            state_d = ST_SEARCH;
            sreg_d  = '0;
            fill_d  = '0;
            wbit_d  = '0;
            werr_d  = '0;
          end else if (wbit_q == WBIT_LAST) begin
            wbit_d = '0;
            werr_d = '0;
          end else begin
            wbit_d = wbit_q + WBIT_W'(1);
            werr_d = werr_nxt;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SEARCH;
      sreg_q   <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      wbit_q   <= '0;
      werr_q   <= '0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      wbit_q   <= wbit_d;
      werr_q   <= werr_d;
      pulse_q  <= pulse_d;
      locked_q <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;

`ifdef PRBS_CHK_ERRCNT_EN
  logic [CNT_W-1:0] ecnt_q, ecnt_d;

  // clear beats a coincident error
  always_comb begin
    ecnt_d = ecnt_q;
    if (cnt_clr)
      ecnt_d = '0;
    else if (err_hit && ecnt_q != '1)
      ecnt_d = ecnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt_q <= '0;
    else        ecnt_q <= ecnt_d;
  end

  assign err_cnt = ecnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = cnt_clr ^ err_hit;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised and directed bench for prbs_checker against a queue-based
// behavioural model of the lock / error-monitor rules.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n, din_vld, din, cnt_clr;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;

  prbs_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_vld   (din_vld),
    .din       (din),
    .cnt_clr   (cnt_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

`ifdef PRBS_CHK_ERRCNT_EN
  localparam bit ECNT_EN = 1'b1;
`else
  localparam bit ECNT_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int TAPK[4] = '{26, 6, 2, 1};
  bit m_hist[$];        // m_hist[k-1] = b[n-k]
  int m_st, m_fill, m_match, m_wbit, m_werr, m_ecnt;
  bit m_pulse;

  function automatic void m_clear_hist();
    m_hist = {};
    for (int i = 0; i < 26; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic void m_reset();
    m_clear_hist();
    m_st = 0; m_fill = 0; m_match = 0; m_wbit = 0; m_werr = 0; m_ecnt = 0;
    m_pulse = 0;
  endfunction

  function automatic void m_push(bit b);
    m_hist.push_front(b);
    void'(m_hist.pop_back());
  endfunction

  function automatic void m_step(bit v, bit d, bit c);
    bit p, nz, err;
    m_pulse = 0;
    if (v) begin
      p = 0;
      foreach (TAPK[i]) p ^= m_hist[TAPK[i]-1];
      case (m_st)
        0: begin
          m_push(d);
          if (m_fill < 26) m_fill++;
          nz = 0;
          foreach (m_hist[i]) nz |= m_hist[i];
          if (m_fill == 26 && nz) begin m_st = 1; m_match = 0; end
        end
        1: begin
          m_push(d);
          if (d == p) begin
            m_match++;
            if (m_match == 32) begin m_st = 2; m_wbit = 0; m_werr = 0; end
          end else begin
            m_match = 0; m_fill = 0; m_st = 0;
          end
        end
        default: begin
          m_push(p);
          err = (d != p);
          if (err) begin
            m_pulse = 1;
            if (m_ecnt < 65535) m_ecnt++;
            m_werr++;
          end
          if (m_werr == 16) begin
            m_st = 0; m_clear_hist(); m_fill = 0; m_wbit = 0; m_werr = 0;
          end else if (m_wbit == 1023) begin
            m_wbit = 0; m_werr = 0;
          end else begin
            m_wbit++;
          end
        end
      endcase
    end
    if (c) m_ecnt = 0;
    if (!ECNT_EN) m_ecnt = 0;
  endfunction

  // ---------------- generator ----------------
  logic [25:0] g;
  function automatic bit gen_next();
    bit b;
    b = g[25] ^ g[5] ^ g[1] ^ g[0];
    g = {g[24:0], b};
    return b;
  endfunction

  // ---------------- drivers ----------------
  int pulses = 0;

  task automatic cyc(bit v, bit d, bit c);
    din_vld = v; din = d; cnt_clr = c;
    @(posedge clk);
    m_step(v, d, c);
    @(negedge clk);
    check("locked", locked, 32'(m_st == 2));
    check("err_pulse", err_pulse, 32'(m_pulse));
    check("err_cnt", err_cnt, m_ecnt);
    pulses += int'(err_pulse);
  endtask

  task automatic send(bit err, bit c = 1'b0);
    cyc(1'b1, gen_next() ^ err, c);
  endtask

  // random idle cycles (garbage din) before a valid bit
  task automatic send_r(bit err, bit c = 1'b0);
    while ($urandom_range(0, 1) == 0) cyc(1'b0, 1'($urandom), 1'b0);
    send(err, c);
  endtask

  task automatic do_reset();
    din_vld = 0; din = 0; cnt_clr = 0;
    rst_n = 1'b0;
    #1;
    check("rst_locked", locked, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_cnt", err_cnt, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int p0, any_lock;

  initial begin
    din_vld = 0; din = 0; cnt_clr = 0; rst_n = 1'b0;
    g = 26'b1_1010;
    m_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // clean stream: lock at the 58th bit, no errors over 4000 bits
    for (int i = 1; i <= 58; i++) begin
      send(0);
      if (i == 57) check("prelock57", locked, 0);
    end
    check("lock58", locked, 1);
    repeat (3942) send(0);
    check("clean_lock", locked, 1);
    check("clean_cnt", err_cnt, 0);
    check("clean_pulses", pulses, 0);

    // single inverted bit 500 bits after lock
    repeat (500) send(0);
    p0 = pulses;
    send(1);
    check("single_now", err_pulse, 1);
    repeat (20) send(0);
    check("single_pulses", pulses - p0, 1);
    check("single_cnt", err_cnt, ECNT_EN ? 1 : 0);
    check("single_lock", locked, 1);

    // move to a fresh window (post-lock bit 5120), clearing err_cnt on the way
    send(0, 1'b1);
    repeat (656) send(0);
    for (int j = 0; j < 16; j++) begin
      send(1);
      if (j == 14) check("lol_pre16", locked, 1);
      if (j < 15) repeat (9) send(0);
    end
    check("lol_16", locked, 0);
    check("lol_cnt", err_cnt, ECNT_EN ? 16 : 0);
    for (int i = 1; i <= 58; i++) begin
      send(0);
      if (i == 57) check("relock57", locked, 0);
    end
    check("relock58", locked, 1);

    // 15 errors straddling a window boundary twice must not drop lock
    repeat (1009) send(0);
    repeat (15) send(1);
    repeat (15) send(1);
    check("straddle_lock", locked, 1);
    repeat (1009) send(0);
    // 16th error lands on the last bit of a window
    repeat (1008) send(0);
    repeat (15) send(1);
    check("winend_pre", locked, 1);
    send(1);
    check("winend_lol", locked, 0);

    // reset while locked
    repeat (58) send(0);
    check("mid_lock", locked, 1);
    repeat (100) send(0);
    do_reset();
    for (int i = 1; i <= 58; i++) begin
      send(0);
      if (i == 57) check("rst_relock57", locked, 0);
    end
    check("rst_relock58", locked, 1);

    // constant zero never locks
    do_reset();
    any_lock = 0;
    repeat (500) begin
      cyc(1'b1, 1'b0, 1'b0);
      any_lock |= int'(locked);
    end
    check("zero_nolock", any_lock, 0);

    // 50% valid duty: lock at the 58th valid bit, then clear alongside an error
    do_reset();
    for (int i = 1; i <= 58; i++) begin
      send_r(0);
      if (i == 57) check("duty_pre57", locked, 0);
    end
    check("duty_lock58", locked, 1);
    repeat (40) send_r(0);
    send_r(1);
    repeat (5) send_r(0);
    send_r(1, 1'b1);
    check("clr_pulse", err_pulse, 1);
    check("clr_cnt", err_cnt, 0);
    check("clr_lock", locked, 1);

    // random soak: random valid, sparse errors, occasional clears
    repeat (20000) begin
      bit v, e, c;
      v = ($urandom_range(0, 1) == 1);
      e = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 499) == 0);
      if (v) send(e, c);
      else   cyc(1'b0, 1'($urandom), c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
